// File: rtl/ring_code_decoder.sv
// One-hot ring code decoder and health monitor: decodes the hot-bit position,
// checks each advance for a single-position step, and tracks lock and faults.
module ring_code_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8,
  localparam int IW      = (N > 1) ? $clog2(N) : 1,
  localparam int GW      = $clog2(LOCK_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     ring_in,
  input  logic             adv_en,
  output logic [IW-1:0]    index,
  output logic             valid,
  output logic             locked,
  output logic             wrap,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       dbg_state
);

  // Handshake: adv_en is a strobe with no back-pressure; ring_in is sampled
  // only on cycles where adv_en=1 and every output updates one edge later.

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [IW-1:0]    index_q, index_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             onehot;
  logic [IW-1:0]    pos;
  logic [IW-1:0]    index_next;
  logic             step_ok;

  always_comb begin
    pos = '0;
    for (int i = 0; i < N; i++) begin
      if (ring_in[i]) pos = IW'(i);
    end
  end

  assign onehot     = $onehot(ring_in);
  // Explicit wrap keeps the modulo correct when N is not a power of two.
  assign index_next = (index_q == IW'(N - 1)) ? '0 : index_q + 1'b1;
  assign step_ok    = onehot && (pos == index_next);

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    index_d     = index_q;
    valid_d     = valid_q;
    locked_d    = locked_q;
    wrap_d      = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    if (adv_en) begin
      valid_d = onehot;
      if (onehot) index_d = pos;
      case (state_q)
        UNLOCKED: begin
          if (onehot) begin
            state_d    = ACQUIRE;
            good_cnt_d = '0;
          end
        end
        ACQUIRE: begin
          if (step_ok) begin
            good_cnt_d = good_cnt_q + 1'b1;
            if (good_cnt_q + 1'b1 == GW'(LOCK_CNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else if (onehot) begin
            good_cnt_d = '0;
          end else begin
            state_d = UNLOCKED;
          end
        end
        LOCKED: begin
          if (step_ok) begin
            wrap_d = (index_q == IW'(N - 1)) && (pos == '0);
          end else begin
            err_d    = 1'b1;
            state_d  = UNLOCKED;
            locked_d = 1'b0;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= UNLOCKED;
      good_cnt_q  <= '0;
      index_q     <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      index_q     <= index_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign index     = index_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign wrap      = wrap_q;
  assign err_pulse = err_q;
  assign err_count = err_count_q;
  assign dbg_state = state_q;

endmodule

// File: doc/ring_code_decoder.md
Name: ring_code_decoder

Overview:
- Receive-side companion to the N-bit ring counter. Samples the counter's one-hot ring code and decodes it to a binary position index.
- Checks every advance for one-hot validity and a correct single-position step, and reports lock status, wrap events and a saturating error count.
- Sits beside any ring-counter instance as a decoder and health monitor for downstream logic.

Parameters:
- N, 4, ring width in bits; N >= 2.
- LOCK_CNT, 2, consecutive correct steps required in ACQUIRE before entering LOCKED; >= 1.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset (0 = reset, sampled on posedge clk).
- ring_in  input  N  ring code from counter; bit i advances to bit i+1, bit N-1 wraps to bit 0.
- adv_en  input  1  counter advanced this cycle; sample and evaluate only when 1.
- index  output  $clog2(N)  binary position of the hot bit (last valid).
- valid  output  1  last sample was exactly one-hot.
- locked  output  1  FSM in LOCKED.
- wrap  output  1  one-cycle pulse on a locked N-1 -> 0 step.
- err_pulse  output  1  one-cycle pulse on a fault while LOCKED.
- err_count  output  ERR_W  saturating count of LOCKED faults.

Behaviour:
- All outputs are registered. Reset values (rst=0 at posedge): index=0, valid=0, locked=0, wrap=0, err_pulse=0, err_count=0, state=UNLOCKED, good_cnt=0. Reset overrides adv_en.
- Latency: outputs reflect ring_in one cycle after the posedge at which adv_en=1.
- adv_en=0: index, valid, locked, err_count and state hold; wrap and err_pulse go to 0.
- onehot(ring_in) is true iff exactly one bit is set. All-zero and multi-hot codes are invalid.
- On a sampled cycle:
  - valid <= onehot.
  - If onehot, index <= position of the set bit; otherwise index holds.
- step_ok is true iff onehot and enc(ring_in) == (index + 1) mod N, where index is the current registered value.
- FSM (evaluated only when adv_en=1):
  - UNLOCKED: onehot -> ACQUIRE with good_cnt=0. Invalid -> stay. No error is counted.
  - ACQUIRE:
    - step_ok -> good_cnt+1; when good_cnt+1 == LOCK_CNT go to LOCKED and set locked=1 on the same edge.
    - Onehot but wrong step -> stay, good_cnt=0.
    - Invalid -> UNLOCKED.
  - LOCKED:
    - step_ok -> stay. wrap=1 if index==N-1 and the new position is 0.
    - Anything else (invalid, skip, repeat, backward) -> err_pulse=1, err_count+1 (saturating at all-ones), go to UNLOCKED, locked=0.
- The fault and locked deassertion appear on the same output cycle.
- A repeated position (no shift) while adv_en=1 is a fault.
- err_count is cleared only by reset; it holds at 2^ERR_W-1 once saturated.
- Reset mid-LOCKED returns to the reset values on the next edge; err_count is cleared.
- wrap never asserts outside LOCKED. wrap and err_pulse are mutually exclusive.

Test Plan:
- Reset: rst=0 for 2 cycles with random ring_in and adv_en=1 -> all outputs 0, locked=0.
- Acquire (N=4, LOCK_CNT=2): adv_en=1 each cycle, ring_in 0000,0001,0010,0100,1000,0001 -> valid=0 then 1; index 0,1,2,3,0; locked=1 after the 0100 sample; wrap=1 exactly on the 1000->0001 output cycle.
- Multi-hot in LOCKED: inject 0110 -> valid=0, err_pulse=1 for one cycle, err_count=1, locked=0, index holds 1. Resume 1000,0001,0010 -> relock after 2 good steps with err_count still 1.
- Skip and stall in LOCKED: 0001->0100 -> err_pulse, err_count+1. Relock, then hold 0010 for two sampled cycles -> fault on the repeat. Hold 0010 with adv_en=0 for 5 cycles -> no fault, all outputs stable.
- Saturation (ERR_W=2): force 5 LOCKED faults -> err_count 1,2,3,3,3 while err_pulse still pulses each time.
- Reset mid-operation: rst=0 for one cycle while locked with err_count=2 -> next cycle locked=0, err_count=0, index=0. Reacquisition requires the full LOCK_CNT sequence.
